// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - parallel-to-serial shift sequencer with serial capture and latch pulse
module shift_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int DIV   = 4,
    parameter int LW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [LW-1:0]    len,
    input  logic             abort,
    input  logic             sin,
    output logic             sout,
    output logic             shift_en,
    output logic             latch,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic [LW-1:0]    len_eff;
    logic             strobe;
    logic             last_bit;
    logic             accept;

    // Out-of-range lengths (0 or beyond WIDTH) fall back to a full-word shift.
    assign len_eff  = ((len == '0) || (len > LW'(WIDTH))) ? LW'(WIDTH) : len;
    assign strobe   = (state == SHIFT) && (div_cnt == DW'(DIV - 1));
    assign last_bit = (bit_cnt == (len_q - LW'(1)));
    assign accept   = (state == IDLE) && load_valid && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shift_en   = 1'b0;
        latch      = 1'b0;
        busy       = 1'b1;
        load_ready = 1'b0;
        case (state)
            IDLE: begin
                busy       = 1'b0;
                load_ready = 1'b1;
                if (accept) state_nx = SHIFT;
            end
            SHIFT: begin
                shift_en = strobe;
                if (abort) begin
                    state_nx = IDLE;
                end else if (strobe && last_bit) begin
                    state_nx = LATCH;
                end
            end
            LATCH: begin
                latch    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr    <= '0;
            rx_sr    <= '0;
            len_q    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            sout     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_sr   <= load_data;
                        len_q   <= len_eff;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        rx_sr   <= '0;
                        sout    <= load_data[WIDTH-1];
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        sout    <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        div_cnt <= strobe ? '0 : div_cnt + DW'(1);
                        // sout only moves on the strobe edge, so it is held for DIV cycles per bit.
                        if (strobe) begin
                            rx_sr <= {rx_sr[WIDTH-2:0], sin};
                            if (!last_bit) begin
                                tx_sr   <= tx_sr << 1;
                                sout    <= tx_sr[WIDTH-2];
                                bit_cnt <= bit_cnt + LW'(1);
                            end
                        end
                    end
                end
                LATCH: begin
                    sout    <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (!abort) begin
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
